// File: rtl/pmod_blink_driver.sv
// pmod_blink_driver: 8-channel active-low LED driver for a PMOD header.
// Each channel runs OFF / ON / BLINK / ONESHOT on a millisecond time base
// prescaled from the board clock. Settings arrive one at a time over a
// valid/ready port and take effect on the next tick boundary, so every
// channel change is aligned to the shared time base.
// TICK_DIV must be at least 2 so that the tick cycle is never the reset count.

module pmod_blink_driver #(
  parameter int TICK_DIV = 12000,
  parameter int PER_W    = 10
) (
  input  logic             CLK,
  input  logic             BTN_N,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [2:0]       wr_ch,
  input  logic [1:0]       wr_mode,
  input  logic [PER_W-1:0] wr_period,
  output logic [7:0]       led_n,
  output logic             tick
);

  localparam int               PRE_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
  localparam logic [PER_W-1:0] PER_ONE  = PER_W'(1);

  localparam logic [1:0] MODE_OFF     = 2'd0;
  localparam logic [1:0] MODE_ON      = 2'd1;
  localparam logic [1:0] MODE_BLINK   = 2'd2;
  localparam logic [1:0] MODE_ONESHOT = 2'd3;

  // Prescaler and tick
  logic [PRE_W-1:0] presc_r;
  logic [PRE_W-1:0] presc_next_s;
  logic             tick_r;
  logic             tick_next_s;

  // Single pending write slot
  logic             pend_valid_r;
  logic             pend_valid_next_s;
  logic [2:0]       pend_ch_r;
  logic [1:0]       pend_mode_r;
  logic [PER_W-1:0] pend_period_r;
  logic             wr_ready_r;
  logic             accept_s;
  logic             apply_s;

  // Per-channel state
  logic [1:0]       mode_r        [8];
  logic [1:0]       mode_next_s   [8];
  logic [PER_W-1:0] period_r      [8];
  logic [PER_W-1:0] period_next_s [8];
  logic [PER_W-1:0] cnt_r         [8];
  logic [PER_W-1:0] cnt_next_s    [8];
  logic [7:0]       on_r;
  logic [7:0]       on_next_s;
  logic [7:0]       led_n_r;

  assign wr_ready = wr_ready_r;
  assign led_n    = led_n_r;
  assign tick     = tick_r;

  // A write is taken only while the slot is empty; it is applied on the
  // first tick seen with the slot already full, so an accept that lands on a
  // tick cycle waits a full tick period.
  assign accept_s = wr_valid && wr_ready_r;
  assign apply_s  = pend_valid_r && tick_r;

  // Prescaler next count and the tick decode of that count, so tick is a flop.
  always_comb begin
    presc_next_s = presc_r;
    if (presc_r == PRE_LAST) begin
      presc_next_s = '0;
    end else begin
      presc_next_s = presc_r + PRE_ONE;
    end
    tick_next_s = (presc_next_s == PRE_LAST);
  end

  // Prescaler and tick registers.
  always_ff @(posedge CLK or negedge BTN_N) begin
    if (!BTN_N) begin
      presc_r <= '0;
      tick_r  <= 1'b0;
    end else begin
      presc_r <= presc_next_s;
      tick_r  <= tick_next_s;
    end
  end

  // Pending-slot occupancy: apply empties it, accept fills it (never both).
  always_comb begin
    pend_valid_next_s = pend_valid_r;
    if (apply_s) begin
      pend_valid_next_s = 1'b0;
    end else if (accept_s) begin
      pend_valid_next_s = 1'b1;
    end else begin
      pend_valid_next_s = pend_valid_r;
    end
  end

  // Pending slot capture; a zero period is stored as one tick.
  always_ff @(posedge CLK or negedge BTN_N) begin
    if (!BTN_N) begin
      pend_valid_r  <= 1'b0;
      wr_ready_r    <= 1'b1;
      pend_ch_r     <= 3'd0;
      pend_mode_r   <= MODE_OFF;
      pend_period_r <= PER_ONE;
    end else begin
      pend_valid_r <= pend_valid_next_s;
      wr_ready_r   <= ~pend_valid_next_s;
      if (accept_s) begin
        pend_ch_r     <= wr_ch;
        pend_mode_r   <= wr_mode;
        pend_period_r <= (wr_period == '0) ? PER_ONE : wr_period;
      end else begin
        pend_ch_r     <= pend_ch_r;
        pend_mode_r   <= pend_mode_r;
        pend_period_r <= pend_period_r;
      end
    end
  end

  // Per-channel next state: apply restarts the target channel, otherwise
  // each channel advances its BLINK / ONESHOT phase on a tick.
  always_comb begin
    on_next_s = on_r;
    for (int i = 0; i < 8; i++) begin
      mode_next_s[i]   = mode_r[i];
      period_next_s[i] = period_r[i];
      cnt_next_s[i]    = cnt_r[i];
      if (apply_s && (pend_ch_r == 3'(i))) begin
        mode_next_s[i]   = pend_mode_r;
        period_next_s[i] = pend_period_r;
        cnt_next_s[i]    = '0;
        on_next_s[i]     = (pend_mode_r != MODE_OFF);
      end else if (tick_r) begin
        case (mode_r[i])
          MODE_BLINK: begin
            if (cnt_r[i] == (period_r[i] - PER_ONE)) begin
              cnt_next_s[i] = '0;
              on_next_s[i]  = ~on_r[i];
            end else begin
              cnt_next_s[i] = cnt_r[i] + PER_ONE;
            end
          end
          MODE_ONESHOT: begin
            if (cnt_r[i] == (period_r[i] - PER_ONE)) begin
              cnt_next_s[i]  = '0;
              on_next_s[i]   = 1'b0;
              mode_next_s[i] = MODE_OFF;
            end else begin
              cnt_next_s[i] = cnt_r[i] + PER_ONE;
            end
          end
          MODE_ON: begin
            cnt_next_s[i] = cnt_r[i];
          end
          default: begin
            cnt_next_s[i] = cnt_r[i];
          end
        endcase
      end else begin
        cnt_next_s[i] = cnt_r[i];
      end
    end
  end

  // Per-channel registers and the registered active-low LED drive.
  always_ff @(posedge CLK or negedge BTN_N) begin
    if (!BTN_N) begin
      for (int i = 0; i < 8; i++) begin
        mode_r[i]   <= MODE_OFF;
        period_r[i] <= PER_ONE;
        cnt_r[i]    <= '0;
      end
      on_r    <= 8'h00;
      led_n_r <= 8'hFF;
    end else begin
      for (int i = 0; i < 8; i++) begin
        mode_r[i]   <= mode_next_s[i];
        period_r[i] <= period_next_s[i];
        cnt_r[i]    <= cnt_next_s[i];
      end
      on_r    <= on_next_s;
      led_n_r <= ~on_next_s;
    end
  end

endmodule

// File: tb/tb_pmod_blink_driver.sv
// Bench for pmod_blink_driver with a 4-cycle tick. A behavioural model tracks
// ticks elapsed since each channel was applied and derives the LED level
// arithmetically; every cycle the DUT outputs are compared to it.

module tb_pmod_blink_driver;

  localparam int TD = 4;
  localparam int PW = 10;

  logic          CLK = 1'b0;
  logic          BTN_N = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [2:0]    wr_ch = 3'd0;
  logic [1:0]    wr_mode = 2'd0;
  logic [PW-1:0] wr_period = '0;
  logic [7:0]    led_n;
  logic          tick;

  pmod_blink_driver #(.TICK_DIV(TD), .PER_W(PW)) dut (
    .CLK(CLK), .BTN_N(BTN_N), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_ch(wr_ch), .wr_mode(wr_mode), .wr_period(wr_period),
    .led_n(led_n), .tick(tick)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // Model state: cycle index since reset release, pending write, and per
  // channel the settings last applied and ticks elapsed since that apply.
  int cyc;
  bit m_ready;
  bit m_pend;
  int m_pch, m_pmode, m_pper;
  int m_mode [8];
  int m_per  [8];
  int m_k    [8];

  function automatic bit m_on(input int i);
    case (m_mode[i])
      1:       return 1'b1;
      2:       return ((m_k[i] / m_per[i]) % 2) == 0;
      3:       return m_k[i] < m_per[i];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] m_led();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = ~m_on(i);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    cyc = 0;
    m_ready = 1'b1;
    m_pend = 1'b0;
    for (int i = 0; i < 8; i++) begin
      m_mode[i] = 0;
      m_per[i] = 1;
      m_k[i] = 0;
    end
  endtask

  // Called at a falling edge: drive inputs, check this cycle, advance model.
  task automatic step(input bit v, input int ch, input int mode, input int per);
    bit acc, tk;
    wr_valid = v;
    wr_ch = 3'(ch);
    wr_mode = 2'(mode);
    wr_period = PW'(per);
    chk("led_n", {24'd0, led_n}, {24'd0, m_led()});
    chk("wr_ready", {31'd0, wr_ready}, {31'd0, m_ready});
    tk = (cyc % TD) == (TD - 1);
    chk("tick", {31'd0, tick}, {31'd0, tk});
    acc = v && m_ready;
    if (tk) begin
      for (int i = 0; i < 8; i++) m_k[i]++;
      if (m_pend) begin
        m_mode[m_pch] = m_pmode;
        m_per[m_pch] = m_pper;
        m_k[m_pch] = 0;
        m_pend = 1'b0;
        m_ready = 1'b1;
      end
    end
    if (acc) begin
      m_pend = 1'b1;
      m_ready = 1'b0;
      m_pch = ch;
      m_pmode = mode;
      m_pper = (per == 0) ? 1 : per;
    end
    @(negedge CLK);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) step(1'b0, 0, 0, 0);
  endtask

  task automatic do_reset();
    BTN_N = 1'b0;
    wr_valid = 1'b0;
    repeat (5) @(negedge CLK);
    chk("rst_led_n", {24'd0, led_n}, 32'hFF);
    chk("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
    chk("rst_tick", {31'd0, tick}, 32'd0);
    BTN_N = 1'b1;
    m_reset();
  endtask

  initial begin
    int low, phase;
    bit was_ready;
    m_reset();
    @(negedge CLK);

    // 1. Reset values and tick cadence.
    do_reset();

    // 2. BLINK ch2 period 3 written at cycle 0.
    step(1'b1, 2, 2, 3);
    chk("blink_ready_low", {31'd0, wr_ready}, 32'd0);
    idle(3);
    chk("blink_first_on", {24'd0, led_n}, 32'hFB);
    chk("blink_ready_back", {31'd0, wr_ready}, 32'd1);
    idle(11);
    chk("blink_still_on", {24'd0, led_n}, 32'hFB);
    step(1'b0, 0, 0, 0);
    chk("blink_off", {24'd0, led_n}, 32'hFF);
    idle(12);
    chk("blink_on_again", {24'd0, led_n}, 32'hFB);

    // 6. Reset mid-period with ch2 blinking and a write pending.
    step(1'b1, 5, 1, 4);
    @(posedge CLK);
    #2;
    BTN_N = 1'b0;
    #1;
    chk("midrst_led_n", {24'd0, led_n}, 32'hFF);
    chk("midrst_ready", {31'd0, wr_ready}, 32'd1);
    @(negedge CLK);
    do_reset();
    idle(16);
    chk("midrst_no_apply", {24'd0, led_n}, 32'hFF);

    // 3. ONESHOT period 2, then period 0 clamped to 1.
    step(1'b1, 7, 3, 2);
    low = 0;
    for (int j = 0; j < 30; j++) begin
      if (led_n[7] == 1'b0) low++;
      step(1'b0, 0, 0, 0);
    end
    chk("oneshot_p2_len", low, 32'd8);
    chk("oneshot_p2_end", {31'd0, led_n[7]}, 32'd1);
    step(1'b1, 7, 3, 0);
    low = 0;
    for (int j = 0; j < 20; j++) begin
      if (led_n[7] == 1'b0) low++;
      step(1'b0, 0, 0, 0);
    end
    chk("oneshot_p0_len", low, 32'd4);

    // 4. Back-pressure: valid held, ch0 ON then ch1 ON.
    phase = 0;
    for (int j = 0; j < 20 && phase < 2; j++) begin
      was_ready = m_ready;
      step(1'b1, (phase == 0) ? 0 : 1, 1, 5);
      if (was_ready) phase++;
    end
    chk("bp_both_accepted", phase, 32'd2);
    idle(6);
    chk("bp_led_01", {30'd0, led_n[1:0]}, 32'd0);

    // 5. Accept exactly on a tick cycle: applied at the following tick.
    for (int j = 0; j < 12 && !(((cyc % TD) == TD - 1) && m_ready); j++) step(1'b0, 0, 0, 0);
    chk("tick_accept_aligned", {31'd0, tick}, 32'd1);
    step(1'b1, 4, 1, 1);
    chk("tick_accept_not_same", {31'd0, led_n[4]}, 32'd1);
    idle(3);
    chk("tick_accept_before", {31'd0, led_n[4]}, 32'd1);
    step(1'b0, 0, 0, 0);
    chk("tick_accept_applied", {31'd0, led_n[4]}, 32'd0);

    // Randomized writes against the model.
    for (int j = 0; j < 800; j++) begin
      step($urandom_range(0, 2) == 0, $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 6));
    end
    idle(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pmod_blink_driver.md
# pmod_blink_driver

Output-side counterpart to the DIP-switch input path: drives an 8-LED PMOD (active-low outputs) with per-channel OFF / ON / BLINK / ONESHOT behaviour. A controller writes channel settings over a valid/ready port. Time is derived from a millisecond tick prescaled from the 12 MHz board clock. The block sits between control logic (switch decode, future UART command parser) and the PMOD output pins.

## Interface
- TICK_DIV, 12000, clock cycles per tick (1 ms at 12 MHz); legal range ≥ 2
- PER_W, 10, width of the per-channel period in ticks
- CLK  input  1  12 MHz hardware clock; all logic is on the rising edge
- BTN_N  input  1  asynchronous active-low reset; deassertion is synchronous to CLK
- wr_valid  input  1  write request
- wr_ready  output  1  block can accept a write
- wr_ch  input  3  target channel 0..7
- wr_mode  input  2  0 OFF, 1 ON, 2 BLINK, 3 ONESHOT
- wr_period  input  PER_W  half-period (BLINK) or on-time (ONESHOT), in ticks
- led_n  output  8  active-low LED drive; bit i is channel i
- tick  output  1  one-cycle pulse at each tick boundary

## Operation
- **Prescaler:** counts 0..TICK_DIV-1 and wraps. `tick` = 1 during the cycle when the count equals TICK_DIV-1.
- **Per-channel state:** `mode`[1:0], `period`[PER_W-1:0], `cnt`[PER_W-1:0], `on` (1 bit).
- **Registered output:** `led_n[i]` = ~`on[i]`.
- **Write accept:** `wr_valid && wr_ready` at a rising edge captures `wr_ch`/`wr_mode`/`wr_period` into a single pending slot, and `wr_ready` goes 0.
- **Write apply:** a pending write is applied on the first `tick` cycle strictly after the accept cycle. That includes an accept that lands on a tick cycle, which waits for the next tick. On apply:
  - the target channel's `mode` and `period` are loaded;
  - `cnt` is cleared to 0;
  - `on` is set to 1 for ON, BLINK and ONESHOT, and to 0 for OFF;
  - the pending slot clears and `wr_ready` returns to 1.
- **Period clamp:** a `wr_period` of 0 is stored as 1.
- **Channel advance on tick** (only channels not being applied that cycle):
  - OFF and ON: no change.
  - BLINK: if `cnt` == `period`-1, then `cnt` ← 0 and `on` toggles; otherwise `cnt` increments.
  - ONESHOT: if `cnt` == `period`-1, then `on` ← 0, `mode` ← OFF and `cnt` ← 0; otherwise `cnt` increments.
- **Precedence:** apply overrides advance for the target channel in the same cycle. All other channels advance normally.
- **Rewrites:** rewriting a channel mid-blink or mid-oneshot restarts it from the new settings. The old phase is not preserved.

## Timing
- **Reset (BTN_N=0):**
  - prescaler = 0;
  - all `mode` = OFF, `on` = 0, `cnt` = 0, `period` = 1;
  - pending slot empty;
  - `led_n` = 8'hFF, `wr_ready` = 1, `tick` = 0.
- **Reset mid-operation:** takes effect immediately (asynchronous). It discards any pending write and restarts the prescaler.
- **Tick timing:**
  - first `tick` at cycle TICK_DIV-1 after reset release (0-indexed);
  - then every TICK_DIV cycles.
- **Write latency:**
  - `wr_ready` falls 1 cycle after accept;
  - `led_n` reflects an applied write 1 cycle after the applying tick;
  - `wr_ready` rises in that same cycle.
  - Worst-case accept-to-LED latency: TICK_DIV+1 cycles.
- **Throughput:** at most one write per tick period. `wr_valid` held high with `wr_ready` = 0 is ignored, and the write inputs are don't-care in that state.
- **BLINK waveform:** a channel with `period` P produces P ticks on, then P ticks off, repeating. The first on-phase starts at apply.
- **ONESHOT:** the LED is on for exactly P ticks after apply, then off; the channel then reads back as OFF.
- **Counter width:** `cnt` never exceeds `period`-1, so no wrap-around occurs beyond PER_W.

## Test plan
(Run with TICK_DIV=4.)
1. **Reset values:** hold BTN_N=0 for 5 cycles, then release → `led_n`=8'hFF, `wr_ready`=1; `tick` pulses at cycles 3, 7, 11 after release.
2. **BLINK:** write ch2, mode BLINK, period 3 at cycle 0 → `wr_ready` is 0 from cycle 1. The tick at cycle 3 applies the write, so `led_n[2]`=0 and `wr_ready`=1 at cycle 4. `led_n[2]` then toggles every 12 cycles; no other bit changes.
3. **ONESHOT and period clamp:**
   - write ch7, ONESHOT, period 2 → `led_n[7]` low for exactly 8 cycles, then high and stays high;
   - write ch7, ONESHOT, period 0 → low for exactly 4 cycles.
4. **Back-pressure:** assert `wr_valid` continuously with ch0 ON followed by ch1 ON → only one write is accepted per tick; ch0 lights at the first apply and ch1 at the next tick; `wr_ready` is 0 between accept and apply.
5. **Accept on a tick cycle:** accept a write exactly on a tick cycle → it is applied at the following tick (4 cycles later), not the same one.
6. **Reset mid-operation:** with ch2 blinking and a write pending, assert BTN_N mid-period → `led_n`=8'hFF immediately; after release the pending write is never applied and `wr_ready`=1.
